mac_accumulator: RTL and testbench
==================================

# mac_accumulator

Streaming accumulate stage placed directly downstream of the 4x4 array multiplier. It accepts one 8-bit product per beat over a valid/ready handshake and sums a frame of up to LEN products. It then presents the frame sum, beat count and overflow flag on a held output handshake. An optional build adds exact-vs-approximate error statistics for characterising approximate multiplier variants.

## Interface
- LEN, 8: maximum beats per frame; legal range 1..256.
- ACC_W, 16: accumulator and out_sum width; legal range 8..24.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  a product beat is offered.
- in_ready  out  1  the stage accepts a beat this cycle.
- in_p  in  8  multiplier product P for this beat.
- in_a, in_b  in  4 each  multiplier operands for this beat; used only with ERR_STATS_EN.
- in_last  in  1  this beat closes the frame early.
- out_valid  out  1  frame result is held.
- out_ready  in  1  consumer takes the result.
- out_sum  out  ACC_W  frame sum of in_p.
- out_count  out  $clog2(LEN+1)  beats in the frame, 1..LEN.
- out_ovf  out  1  the sum saturated during the frame.
- out_err  out  ACC_W  sum of |in_a*in_b − in_p| over the frame; reads 0 without ERR_STATS_EN.
- out_err_max  out  8  largest single-beat error in the frame; reads 0 without ERR_STATS_EN.

## Operation
- Two states:
  - ACCUM: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- Beat acceptance: a beat is accepted when in_valid && in_ready.
- Per accepted beat:
  - acc ← acc + in_p, computed at ACC_W+1 bits.
  - If the result exceeds 2^ACC_W−1, acc ← all ones and the sticky ovf flag is set.
  - cnt ← cnt+1.
- Closing beat: the beat is closing when cnt==LEN−1 or in_last=1.
- On the closing beat:
  - The updated acc, cnt+1, ovf and the error registers are copied into the output registers.
  - Internal acc, cnt, ovf and error registers clear.
  - The state moves to HOLD.
- HOLD: outputs stay stable until out_valid && out_ready, then the state returns to ACCUM. No input is accepted in HOLD.
- in_last with in_valid=0 has no effect.
- Empty frames do not exist; out_count is never 0.
- Reset, including mid-frame or in HOLD:
  - State → ACCUM; acc, cnt, ovf, error registers and all outputs clear to 0.
  - A partial frame is discarded and never emitted.
- Outputs after reset: in_ready=1 from the first cycle with rst low; out_valid=0, out_sum=0, out_count=0, out_ovf=0, out_err=0, out_err_max=0.
- Error arithmetic: the exact product is 8 bits unsigned; the error is the 8-bit absolute difference, zero-extended into out_err. out_err saturates like out_sum but does not affect out_ovf.

## Timing
- Latency: out_valid rises in the cycle after the closing beat is accepted.
- Throughput:
  - One beat per cycle within a frame.
  - At least one bubble cycle between frames: the HOLD cycle(s), with in_ready low.
- Backpressure:
  - out_valid may not drop, and output data may not change, while out_ready=0.
  - in_ready stays low for the whole HOLD.
- Release: when out_ready is high in HOLD, the handshake completes that cycle and in_ready=1 the next cycle. There is no combinational path from out_ready to in_ready.
- Input stability: in_ready depends only on registered state. Inputs are sampled only on accept.

## Configuration
- ERR_STATS_EN defined:
  - in_a and in_b are used.
  - The exact-product and absolute-error logic is instantiated.
  - out_err and out_err_max are live.
- ERR_STATS_EN undefined:
  - No error logic is built; in_a and in_b are ignored.
  - out_err and out_err_max are tied to 0.
  - All other behaviour is identical.

## Structure
- Package mac_acc_pkg holds:
  - Constants OPND_W=4 and PROD_W=8.
  - The state enum {ACCUM, HOLD}.
  - A function computing the saturating ACC_W add.
- Sub-module abs_err_unit computes the exact in_a*in_b and |exact − in_p|. It is combinational, and is instantiated only under ERR_STATS_EN.
- The main block holds the FSM, counter, accumulators and output registers.

## Test plan
- Full frame, LEN=4, out_ready=1: back-to-back products 10, 20, 30, 40 → out_valid one cycle after the 4th accept, with out_sum=100, out_count=4, out_ovf=0.
- Early close: products 225, 225 with in_last on the 2nd → out_sum=450, out_count=2; the next frame starts with acc=0.
- Backpressure: hold out_ready=0 for 5 cycles in HOLD → out_valid=1, out_sum stable and in_ready=0 throughout. When out_ready goes high, in_ready=1 the following cycle.
- Reset mid-frame: accept 50, 60, pulse rst, then send a full LEN=4 frame of 1s → out_sum=4, out_count=4; no output is emitted for the aborted beats.
- Saturation, ACC_W=8, LEN=4: products 200, 100, 0, 0 → out_sum=255, out_ovf=1. The next frame of 1s gives out_sum=4, out_ovf=0.
- ERR_STATS_EN, frame closed by in_last on the 2nd beat:
  - Beats (a=15, b=15, p=224) and (a=3, b=3, p=9) → out_err=1, out_err_max=1, out_sum=233.
  - The same frame without the macro gives out_err=0, out_err_max=0.

Source files
------------

// File: rtl/mac_acc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mac_acc_pkg
//  Purpose  : Shared constants, FSM state type and saturating-add helpers
//             for the multiplier-product accumulate stage.
//  Revision : 1.0  initial release
// ============================================================================
package mac_acc_pkg;

  // Operand and product widths of the upstream 4x4 array multiplier
  localparam int OPND_W = 4;
  localparam int PROD_W = 8;

  // Widest accumulator the helpers support; callers zero-extend into it
  localparam int ACC_W_MAX = 24;
  localparam logic [ACC_W_MAX:0] SAT_ONE = {{ACC_W_MAX{1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  // Add a and b at one extra bit and clamp to the all-ones value of width w
  function automatic logic [ACC_W_MAX-1:0] sat_add(
    input logic [ACC_W_MAX-1:0] a,
    input logic [ACC_W_MAX-1:0] b,
    input int unsigned          w
  );
    logic [ACC_W_MAX:0] s;
    logic [ACC_W_MAX:0] lim;
    s   = {1'b0, a} + {1'b0, b};
    lim = (SAT_ONE << w) - SAT_ONE;
    if (s > lim) sat_add = lim[ACC_W_MAX-1:0];
    else         sat_add = s[ACC_W_MAX-1:0];
  endfunction

  // Companion flag: true when the same add would have clamped
  function automatic logic sat_ovf(
    input logic [ACC_W_MAX-1:0] a,
    input logic [ACC_W_MAX-1:0] b,
    input int unsigned          w
  );
    logic [ACC_W_MAX:0] s;
    logic [ACC_W_MAX:0] lim;
    s       = {1'b0, a} + {1'b0, b};
    lim     = (SAT_ONE << w) - SAT_ONE;
    sat_ovf = (s > lim);
  endfunction

endpackage
`default_nettype wire

// File: rtl/abs_err_unit.sv
`default_nettype none
// ============================================================================
//  Module   : abs_err_unit
//  Purpose  : Combinational exact 4x4 product and absolute difference from
//             the (possibly approximate) product supplied by the multiplier.
//  Revision : 1.0  initial release
// ============================================================================
module abs_err_unit
  import mac_acc_pkg::*;
(
  input  logic [OPND_W-1:0] a_i,
  input  logic [OPND_W-1:0] b_i,
  input  logic [PROD_W-1:0] p_i,
  output logic [PROD_W-1:0] err_o
);

  logic [PROD_W-1:0] w_exact;

  // 15*15 = 225 fits in 8 bits, so the exact product never wraps
  always_comb begin
    w_exact = PROD_W'(a_i) * PROD_W'(b_i);
    err_o   = (w_exact >= p_i) ? (w_exact - p_i) : (p_i - w_exact);
  end

endmodule
`default_nettype wire

// File: rtl/mac_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : mac_accumulator
//  Purpose  : Frame accumulator for multiplier products. Sums up to LEN
//             beats (or until in_last) with saturation, then holds the frame
//             sum, beat count and overflow flag on an output handshake.
//  Options  : ERR_STATS_EN - adds exact-vs-approximate error sum and
//             per-frame maximum error (out_err / out_err_max); when
//             undefined those outputs read 0 and in_a / in_b are ignored.
//  Revision : 1.0  initial release
// ============================================================================
module mac_accumulator
  import mac_acc_pkg::*;
#(
  parameter int LEN   = 8,
  parameter int ACC_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [PROD_W-1:0]          in_p,
  input  logic [OPND_W-1:0]          in_a,
  input  logic [OPND_W-1:0]          in_b,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ACC_W-1:0]           out_sum,
  output logic [$clog2(LEN+1)-1:0]   out_count,
  output logic                       out_ovf,
  output logic [ACC_W-1:0]           out_err,
  output logic [PROD_W-1:0]          out_err_max
);

  localparam int CNT_W = $clog2(LEN + 1);

  state_e             state_q;
  logic [ACC_W-1:0]   acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               ovf_q;
  logic [ACC_W-1:0]   out_sum_q;
  logic [CNT_W-1:0]   out_count_q;
  logic               out_ovf_q;

  logic [ACC_W-1:0]   acc_d;
  logic [CNT_W-1:0]   cnt_d;
  logic               ovf_d;
  logic               w_accept;
  logic               w_close;

  // Handshake flags decode straight from the registered state
  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);

  assign out_sum   = out_sum_q;
  assign out_count = out_count_q;
  assign out_ovf   = out_ovf_q;

  // Per-beat next values: saturating sum, sticky overflow, incremented count
  always_comb begin
    w_accept = in_valid && (state_q == ACCUM);
    w_close  = w_accept && ((cnt_q == CNT_W'(LEN - 1)) || in_last);
    acc_d    = ACC_W'(sat_add(ACC_W_MAX'(acc_q), ACC_W_MAX'(in_p), ACC_W));
    ovf_d    = ovf_q | sat_ovf(ACC_W_MAX'(acc_q), ACC_W_MAX'(in_p), ACC_W);
    cnt_d    = cnt_q + CNT_W'(1);
  end

  // FSM, frame accumulators and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (w_accept) begin
            if (w_close) begin
              out_sum_q   <= acc_d;
              out_count_q <= cnt_d;
              out_ovf_q   <= ovf_d;
              acc_q       <= '0;
              cnt_q       <= '0;
              ovf_q       <= 1'b0;
              state_q     <= HOLD;
            end else begin
              acc_q <= acc_d;
              cnt_q <= cnt_d;
              ovf_q <= ovf_d;
            end
          end
        end
        HOLD: begin
          if (out_ready) state_q <= ACCUM;
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

`ifdef ERR_STATS_EN
  logic [PROD_W-1:0] w_beat_err;
  logic [ACC_W-1:0]  err_q;
  logic [PROD_W-1:0] emax_q;
  logic [ACC_W-1:0]  out_err_q;
  logic [PROD_W-1:0] out_err_max_q;
  logic [ACC_W-1:0]  err_d;
  logic [PROD_W-1:0] emax_d;

  abs_err_unit u_abs_err (
    .a_i   (in_a),
    .b_i   (in_b),
    .p_i   (in_p),
    .err_o (w_beat_err)
  );

  // Error sum saturates like the product sum but never touches out_ovf
  always_comb begin
    err_d  = ACC_W'(sat_add(ACC_W_MAX'(err_q), ACC_W_MAX'(w_beat_err), ACC_W));
    emax_d = (w_beat_err > emax_q) ? w_beat_err : emax_q;
  end

  // Error statistics follow the same accept/close timing as the sum
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q         <= '0;
      emax_q        <= '0;
      out_err_q     <= '0;
      out_err_max_q <= '0;
    end else if (w_accept) begin
      if (w_close) begin
        out_err_q     <= err_d;
        out_err_max_q <= emax_d;
        err_q         <= '0;
        emax_q        <= '0;
      end else begin
        err_q  <= err_d;
        emax_q <= emax_d;
      end
    end
  end

  assign out_err     = out_err_q;
  assign out_err_max = out_err_max_q;
`else
  // Operands only matter for error statistics; fold them away here
  logic w_unused_operands;
  assign w_unused_operands = ^{in_a, in_b};

  assign out_err     = '0;
  assign out_err_max = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mac_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mac_accumulator
//  Purpose  : Directed scoreboard bench. Two instances (ACC_W=16 and ACC_W=8,
//             both LEN=4) share one input stream; each has its own expected
//             queue and monitor.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mac_accumulator;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_p;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic       in_last;
  logic       out_ready;

  logic        rdy_a, va;
  logic [15:0] sum_a, err_a;
  logic [2:0]  cnt_a;
  logic        ovf_a;
  logic [7:0]  emax_a;

  logic        rdy_b, vb;
  logic [7:0]  sum_b, err_b;
  logic [2:0]  cnt_b;
  logic        ovf_b;
  logic [7:0]  emax_b;

  int checks   = 0;
  int failures = 0;

`ifdef ERR_STATS_EN
  localparam bit ES = 1'b1;
`else
  localparam bit ES = 1'b0;
`endif

  typedef struct {
    int sum;
    int cnt;
    int ovf;
    int err;
    int emax;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  always #5 clk = ~clk;

  mac_accumulator #(.LEN(4), .ACC_W(16)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_a),
    .in_p(in_p), .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .out_valid(va), .out_ready(out_ready), .out_sum(sum_a),
    .out_count(cnt_a), .out_ovf(ovf_a), .out_err(err_a), .out_err_max(emax_a)
  );

  mac_accumulator #(.LEN(4), .ACC_W(8)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_b),
    .in_p(in_p), .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .out_valid(vb), .out_ready(out_ready), .out_sum(sum_b),
    .out_count(cnt_b), .out_ovf(ovf_b), .out_err(err_b), .out_err_max(emax_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Push hand-computed results for both instances (err fields live only with ES)
  task automatic push(input int cnt, input int sa, input int oa, input int sb, input int ob,
                      input int ea, input int eb, input int emax);
    exp_t e;
    e.cnt = cnt; e.sum = sa; e.ovf = oa; e.err = ES ? ea : 0; e.emax = ES ? emax : 0;
    qa.push_back(e);
    e.sum = sb; e.ovf = ob; e.err = ES ? eb : 0;
    qb.push_back(e);
  endtask

  task automatic send(input int p, input int a, input int b, input bit last);
    bit ok;
    logic [31:0] pv, av, bv;
    ok = 1'b0;
    pv = p; av = a; bv = b;
    in_valid = 1'b1; in_p = pv[7:0]; in_a = av[3:0]; in_b = bv[3:0]; in_last = last;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      if (rdy_a && rdy_b) ok = 1'b1;
      @(posedge clk); #1;
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL send_timeout actual=not_ready required=ready");
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  // Monitor A: compare on each completed output handshake
  always @(negedge clk) begin
    if (!rst && va && out_ready) begin
      if (qa.size() == 0) begin
        checks++; failures++;
        $display("FAIL A_unexpected_out actual=sum%0d required=no_output", sum_a);
      end else begin
        exp_t e;
        e = qa.pop_front();
        chk("A_sum", sum_a, e.sum);
        chk("A_count", cnt_a, e.cnt);
        chk("A_ovf", ovf_a, e.ovf);
        chk("A_err", err_a, e.err);
        chk("A_err_max", emax_a, e.emax);
      end
    end
  end

  // Monitor B: same for the narrow-accumulator instance
  always @(negedge clk) begin
    if (!rst && vb && out_ready) begin
      if (qb.size() == 0) begin
        checks++; failures++;
        $display("FAIL B_unexpected_out actual=sum%0d required=no_output", sum_b);
      end else begin
        exp_t e;
        e = qb.pop_front();
        chk("B_sum", sum_b, e.sum);
        chk("B_count", cnt_b, e.cnt);
        chk("B_ovf", ovf_b, e.ovf);
        chk("B_err", err_b, e.err);
        chk("B_err_max", emax_b, e.emax);
      end
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_p = '0; in_a = '0; in_b = '0; in_last = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_in_ready", rdy_a, 1);
    chk("rst_out_valid", va, 0);
    chk("rst_out_sum", sum_a, 0);
    chk("rst_out_count", cnt_a, 0);
    chk("rst_out_ovf", ovf_a, 0);
    chk("rst_out_err", err_a, 0);
    chk("rst_out_err_max", emax_a, 0);
    chk("rst_B_out_valid", vb, 0);
    @(posedge clk); #1;

    // Full frame, closed by count
    push(4, 100, 0, 100, 0, 100, 100, 40);
    send(10, 0, 0, 0);
    send(20, 0, 0, 0);
    send(30, 0, 0, 0);
    chk("mid_frame_out_valid", va, 0);
    send(40, 0, 0, 0);
    chk("latency_out_valid", va, 1);
    chk("hold_in_ready", rdy_a, 0);

    // Early close via in_last; B saturates
    push(2, 450, 0, 255, 1, 450, 255, 225);
    send(225, 0, 0, 0);
    send(225, 0, 0, 1);

    // Backpressure in HOLD
    push(3, 18, 0, 18, 0, 18, 18, 7);
    send(5, 0, 0, 0);
    send(6, 0, 0, 0);
    out_ready = 1'b0;
    send(7, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_valid", va, 1);
      chk("bp_in_ready", rdy_a, 0);
      chk("bp_out_sum", sum_a, 18);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    chk("release_in_ready_same_cycle", rdy_a, 0);
    @(posedge clk); #1;
    chk("release_in_ready_next", rdy_a, 1);
    chk("release_out_valid", va, 0);

    // Reset mid-frame discards partial beats
    send(50, 0, 0, 0);
    send(60, 0, 0, 0);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", rdy_a, 1);
    chk("midrst_out_valid", va, 0);
    chk("midrst_out_sum", sum_a, 0);
    @(posedge clk); #1;
    push(4, 4, 0, 4, 0, 4, 4, 1);
    for (int i = 0; i < 4; i++) send(1, 0, 0, 0);

    // Saturation on B, sum fits on A
    push(4, 300, 0, 255, 1, 300, 255, 200);
    send(200, 0, 0, 0);
    send(100, 0, 0, 0);
    send(0, 0, 0, 0);
    send(0, 0, 0, 0);

    // in_last without in_valid must not close anything
    in_last = 1'b1;
    repeat (2) @(posedge clk);
    #1 in_last = 1'b0;

    // Next frame: overflow flag cleared
    push(4, 4, 0, 4, 0, 4, 4, 1);
    for (int i = 0; i < 4; i++) send(1, 0, 0, 0);

    // Approximate-product frame for error statistics
    push(2, 233, 0, 233, 0, 1, 1, 1);
    send(224, 15, 15, 0);
    send(9, 3, 3, 1);

    // Drain scoreboard with a bounded wait
    for (int k = 0; k < 50 && (qa.size() != 0 || qb.size() != 0); k++) @(posedge clk);
    if (qa.size() != 0 || qb.size() != 0) begin
      checks++; failures++;
      $display("FAIL drain actual=%0d/%0d_pending required=0", qa.size(), qb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
